pipe_skid_reg: RTL and testbench

//   Parametrised pipeline register with a valid/ready handshake and a 2-entry skid buffer.

---
 rtl/pipe_skid_reg.sv | 103 ++++++++++
 tb/tb_pipe_skid_reg.sv | 128 ++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: valid/ready pipeline register with a 2-entry skid buffer and synchronous flush
//   Every output is decoded from flops, so neither out_ready -> in_ready nor in_* -> out_*
//   has a combinational path.
//   Optional macro PIPE_SKID_STATS_EN adds the stall_cnt port and its counter.
//   Ports:
//     clk        rising-edge clock
//     rst        asynchronous active-high reset
//     flush      synchronous squash of all held entries
//     in_valid   upstream presents in_data
//     in_ready   stage can accept in_data this cycle
//     in_data    upstream payload
//     out_valid  out_data is valid
//     out_ready  downstream accepts out_data this cycle
//     out_data   payload at the head of the stage
//     occupancy  entries held (0..2)
//     stall_cnt  saturating count of cycles with out_valid & !out_ready (stats build only)
module pipe_skid_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
`ifdef PIPE_SKID_STATS_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);
    // State encoding equals the entry count, so occupancy is the state itself.
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
    logic             in_fire, out_fire;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = RESET_VAL;
            skid_d  = RESET_VAL;
        end else begin
            case (state_q)
                EMPTY: if (in_fire) begin
                    state_d = ONE;
                    main_d  = in_data;
                end
                ONE: if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    state_d = FULL;
                    skid_d  = in_data;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
                // in_ready is low when FULL, so only the drain case exists here.
                FULL: if (out_fire) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
                default: state_d = EMPTY;
            endcase
        end
    end
    always_comb begin
        in_ready  = state_q != FULL;
        out_valid = state_q != EMPTY;
        occupancy = state_q;
        out_data  = main_q;
    end
`ifdef PIPE_SKID_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    // Saturates rather than wraps; flush deliberately leaves it alone.
    always_comb begin
        stall_cnt_d = (out_valid && !out_ready && stall_cnt_q != 32'hFFFF_FFFF) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end
    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed vector bench for pipe_skid_reg
module tb_pipe_skid_reg;
    localparam int          W  = 32;
    localparam logic [W-1:0] RV = 32'hDEAD_BEEF;
    logic         clk = 1'b0;
    logic         rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] in_data, out_data;
    logic [1:0]   occupancy;
`ifdef PIPE_SKID_STATS_EN
    logic [31:0]  stall_cnt;
`endif
    always #5 clk = ~clk;
    pipe_skid_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
`ifdef PIPE_SKID_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );
    typedef struct {
        logic         fl;
        logic         iv;
        logic [W-1:0] id;
        logic         ordy;
        logic         ov;
        logic         ir;
        logic [1:0]   occ;
        logic [W-1:0] od;
    } vec_t;
    vec_t vq[$];
    int n_vec = 0;
    int n_bad = 0;
    task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask
    task automatic chk_all(input string nm, input logic ov, input logic ir, input logic [1:0] occ, input logic [W-1:0] od);
        chk({nm, ".out_valid"}, W'(out_valid), W'(ov));
        chk({nm, ".in_ready"}, W'(in_ready), W'(ir));
        chk({nm, ".occupancy"}, W'(occupancy), W'(occ));
        chk({nm, ".out_data"}, out_data, od);
    endtask
    task automatic drive(input logic fl, input logic iv, input logic [W-1:0] id, input logic ordy);
        flush     = fl;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask
    initial begin
        // streaming 1..8: one-cycle latency, occupancy stays 1
        for (int i = 0; i < 8; i++)
            vq.push_back('{1'b0, 1'b1, W'(i + 1), 1'b1, 1'b1, 1'b1, 2'd1, W'(i + 1)});
        vq.push_back('{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 2'd0, 32'h8});
        // backpressure: A, B fill; C refused while full; drain A then B
        vq.push_back('{1'b0, 1'b1, 32'hA,  1'b0, 1'b1, 1'b1, 2'd1, 32'hA});
        vq.push_back('{1'b0, 1'b1, 32'hB,  1'b0, 1'b1, 1'b0, 2'd2, 32'hA});
        vq.push_back('{1'b0, 1'b1, 32'hC,  1'b0, 1'b1, 1'b0, 2'd2, 32'hA});
        vq.push_back('{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 2'd1, 32'hB});
        vq.push_back('{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 2'd0, 32'hB});
        // flush while full with a competing in_fire: 0x33 is dropped
        vq.push_back('{1'b0, 1'b1, 32'h11, 1'b0, 1'b1, 1'b1, 2'd1, 32'h11});
        vq.push_back('{1'b0, 1'b1, 32'h22, 1'b0, 1'b1, 1'b0, 2'd2, 32'h11});
        vq.push_back('{1'b1, 1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 2'd0, RV});
        vq.push_back('{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 2'd0, RV});
        // flush while empty beats an in_fire
        vq.push_back('{1'b1, 1'b1, 32'h44, 1'b1, 1'b0, 1'b1, 2'd0, RV});
        vq.push_back('{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 2'd0, RV});
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_all("reset", 1'b0, 1'b1, 2'd0, RV);
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].fl, vq[i].iv, vq[i].id, vq[i].ordy);
            chk_all($sformatf("vec%0d", i), vq[i].ov, vq[i].ir, vq[i].occ, vq[i].od);
        end
        // simultaneous in/out fire for 16 cycles from occupancy 1
        drive(1'b0, 1'b1, 32'h100, 1'b0);
        chk_all("sim_load", 1'b1, 1'b1, 2'd1, 32'h100);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 32'h101 + W'(i), 1'b1);
            chk_all($sformatf("sim%0d", i), 1'b1, 1'b1, 2'd1, 32'h101 + W'(i));
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        chk_all("hold", 1'b1, 1'b1, 2'd1, 32'h110);
        drive(1'b0, 1'b1, 32'h200, 1'b0);
        chk_all("fill", 1'b1, 1'b0, 2'd2, 32'h110);
        // async reset between clock edges while full
        #3 rst = 1'b1;
        #1 chk_all("async_rst", 1'b0, 1'b1, 2'd0, RV);
        #2 rst = 1'b0;
        drive(1'b0, 1'b1, 32'h300, 1'b1);
        chk_all("post_rst", 1'b1, 1'b1, 2'd1, 32'h300);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk_all("post_rst_drain", 1'b0, 1'b1, 2'd0, 32'h300);
`ifdef PIPE_SKID_STATS_EN
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        chk("stall_rst", stall_cnt, 32'd0);
        drive(1'b0, 1'b1, 32'h5, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 32'h0, 1'b0);
        chk("stall5", stall_cnt, 32'd5);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        chk("stall_flush", stall_cnt, 32'd5);
        #2 rst = 1'b1;
        #1 chk("stall_async_rst", stall_cnt, 32'd0);
        #1 rst = 1'b0;
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1 release dut.stall_cnt_q;
        drive(1'b0, 1'b1, 32'h5, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 32'h0, 1'b0);
        chk("stall_sat", stall_cnt, 32'hFFFF_FFFF);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
